// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and instruction field helpers for the 4-bit CPU sequencer.
package ctrl_pkg;

  localparam int DATA_W  = 4;
  localparam int REG_W   = 2;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;

  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 4;
  localparam int RS_LSB  = 2;
  localparam int RT_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_JNZ = 2'b11;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

  function automatic logic [1:0] op_of(input logic [INSTR_W-1:0] i);
    return i[OP_LSB +: 2];
  endfunction

  function automatic logic [REG_W-1:0] rd_of(input logic [INSTR_W-1:0] i);
    return i[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rs_of(input logic [INSTR_W-1:0] i);
    return i[RS_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rt_of(input logic [INSTR_W-1:0] i);
    return i[RT_LSB +: REG_W];
  endfunction

  function automatic logic [DATA_W-1:0] imm_of(input logic [INSTR_W-1:0] i);
    return i[IMM_LSB +: DATA_W];
  endfunction

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit add/subtract; carry and borrow fall off the top (modulo 16).
module alu4
  import ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving the register file selects and write port.
// Optional single-step mode: define CTRL_STEP_EN to add the step input.
module ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
`ifdef CTRL_STEP_EN
  input  logic               step,
`endif
  output logic               instr_req,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    pc,
  output logic [REG_W-1:0]   sel_a,
  output logic [REG_W-1:0]   sel_b,
  output logic [REG_W-1:0]   sel_w,
  output logic               write_en,
  output logic [DATA_W-1:0]  wr_data,
  input  logic [DATA_W-1:0]  rd_a,
  input  logic [DATA_W-1:0]  rd_b
);

  // Handshake: an instruction transfers on a rising edge where instr_req and
  // instr_valid are both high; instr_valid is ignored whenever instr_req is low.

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  result;
  logic [DATA_W-1:0]  alu_y;
  logic               is_sub;

  assign is_sub  = (op_of(ir) == OP_SUB);
  assign wr_data = result;

  alu4 u_alu (
    .a   (rd_a),
    .b   (rd_b),
    .sub (is_sub),
    .y   (alu_y)
  );

`ifdef CTRL_STEP_EN
  logic step_seen;
  assign instr_req = (state == FETCH) && step_seen;
`else
  assign instr_req = (state == FETCH);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= '0;
      ir       <= '0;
      result   <= '0;
      sel_a    <= '0;
      sel_b    <= '0;
      sel_w    <= '0;
      write_en <= 1'b0;
`ifdef CTRL_STEP_EN
      step_seen <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
`ifdef CTRL_STEP_EN
          if (step) step_seen <= 1'b1;
`endif
          if (instr_req && instr_valid) begin
            ir <= instr_data;
            // Selects are loaded with the IR so they are already valid during DECODE.
            sel_a <= (op_of(instr_data) == OP_JNZ) ? rd_of(instr_data) : rs_of(instr_data);
            sel_b <= rt_of(instr_data);
            state <= DECODE;
`ifdef CTRL_STEP_EN
            step_seen <= 1'b0;
`endif
          end
        end
        DECODE: state <= EXEC;
        EXEC: begin
          if (op_of(ir) == OP_JNZ) begin
            pc    <= (rd_a != '0) ? imm_of(ir) : pc + PC_W'(1);
            state <= FETCH;
          end else begin
            result   <= (op_of(ir) == OP_LDI) ? imm_of(ir) : alu_y;
            sel_w    <= rd_of(ir);
            write_en <= 1'b1;
            state    <= WB;
          end
        end
        WB: begin
          write_en <= 1'b0;
          pc       <= pc + PC_W'(1);
          state    <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed vector table, stall/abort sequences, and random
// instructions checked against an arithmetic model of the CPU plus a write scoreboard.
module tb_ctrl_fsm;

`ifdef CTRL_STEP_EN
  localparam bit STEP_MODE = 1'b1;
  logic step;
`else
  localparam bit STEP_MODE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       instr_req;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [3:0] pc;
  logic [1:0] sel_a, sel_b, sel_w;
  logic       write_en;
  logic [3:0] wr_data;
  logic [3:0] rd_a, rd_b;

  int errors = 0;
  int checks = 0;

  logic [5:0] exp_q[$];
  logic [3:0] rf [4] = '{default: 4'd0};
  int         m_regs [4] = '{default: 0};
  int         m_pc = 0;

  ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef CTRL_STEP_EN
    .step        (step),
`endif
    .instr_req   (instr_req),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .pc          (pc),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .sel_w       (sel_w),
    .write_en    (write_en),
    .wr_data     (wr_data),
    .rd_a        (rd_a),
    .rd_b        (rd_b)
  );

  // Clock / reset environment and external register file
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_a = rf[sel_a];
  assign rd_b = rf[sel_b];
  always @(posedge clk) if (write_en) rf[sel_w] <= wr_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected {rd, value}
  always @(negedge clk) begin
    if (write_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got sel_w=%0d data=%0d expected no write", sel_w, wr_data);
      end else begin
        chk("wr_scoreboard", {sel_w, wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int waited = 0;
`ifdef CTRL_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
    while (!instr_req && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_req"}, instr_req, 1);
  endtask

  // Reference model: architectural effect of one instruction
  task automatic model_step(input logic [7:0] instr, output logic [1:0] esa, output logic [1:0] esb,
                            output logic ewe, output logic [1:0] esw, output logic [3:0] ewd,
                            output logic [3:0] epc);
    int op, rd, rs, rt, imm, v;
    op  = instr / 64;
    rd  = (instr / 16) % 4;
    rs  = (instr / 4) % 4;
    rt  = instr % 4;
    imm = instr % 16;
    esa = 2'((op == 3) ? rd : rs);
    esb = 2'(rt);
    case (op)
      0:       v = (m_regs[rs] + m_regs[rt]) % 16;
      1:       v = (m_regs[rs] - m_regs[rt] + 16) % 16;
      default: v = imm;
    endcase
    if (op == 3) begin
      ewe  = 1'b0;
      esw  = 2'd0;
      ewd  = 4'd0;
      m_pc = (m_regs[rd] != 0) ? imm : (m_pc + 1) % 16;
    end else begin
      ewe        = 1'b1;
      esw        = 2'(rd);
      ewd        = 4'(v);
      m_regs[rd] = v;
      m_pc       = (m_pc + 1) % 16;
    end
    epc = 4'(m_pc);
  endtask

  task automatic run_instr(input string tag, input logic [7:0] instr, input logic [3:0] pc_before,
                           input logic [1:0] esa, input logic [1:0] esb, input logic ewe,
                           input logic [1:0] esw, input logic [3:0] ewd, input logic [3:0] epc);
    wait_req(tag);
    chk({tag, "_pc_before"}, pc, pc_before);
    if (ewe) exp_q.push_back({esw, ewd});
    instr_valid = 1'b1;
    instr_data  = instr;
    tick();  // transfer edge; now in the 1st cycle after transfer
    instr_valid = 1'($urandom_range(0, 1));
    instr_data  = 8'($urandom);
    chk({tag, "_sel_a"}, sel_a, esa);
    chk({tag, "_sel_b"}, sel_b, esb);
    chk({tag, "_c1_req"}, instr_req, 0);
    chk({tag, "_c1_we"}, write_en, 0);
    tick();
    chk({tag, "_c2_sel_a"}, sel_a, esa);
    chk({tag, "_c2_we"}, write_en, 0);
    chk({tag, "_c2_req"}, instr_req, 0);
    tick();
    if (ewe) begin
      chk({tag, "_c3_we"}, write_en, 1);
      chk({tag, "_c3_sel_w"}, sel_w, esw);
      chk({tag, "_c3_wr_data"}, wr_data, ewd);
      chk({tag, "_c3_req"}, instr_req, 0);
      tick();
    end
    instr_valid = 1'b0;
    chk({tag, "_end_we"}, write_en, 0);
    chk({tag, "_end_req"}, instr_req, STEP_MODE ? 0 : 1);
    chk({tag, "_pc_after"}, pc, epc);
  endtask

  typedef struct {
    logic [7:0] instr;
    logic [1:0] sa, sb;
    logic       we;
    logic [1:0] sw;
    logic [3:0] wd;
    logic [3:0] pc;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [1:0] esa, esb, esw;
    logic       ewe;
    logic [3:0] ewd, epc, pc0;
    logic [7:0] instr;

    vecs[0]  = '{8'h95, 2'd1, 2'd1, 1'b1, 2'd1, 4'd5,  4'd1};   // LDI r1,5
    vecs[1]  = '{8'h99, 2'd2, 2'd1, 1'b1, 2'd1, 4'd9,  4'd2};   // LDI r1,9
    vecs[2]  = '{8'h25, 2'd1, 2'd1, 1'b1, 2'd2, 4'd2,  4'd3};   // ADD r2,r1,r1 -> 18 mod 16
    vecs[3]  = '{8'h91, 2'd0, 2'd1, 1'b1, 2'd1, 4'd1,  4'd4};   // LDI r1,1
    vecs[4]  = '{8'h71, 2'd0, 2'd1, 1'b1, 2'd3, 4'd15, 4'd5};   // SUB r3,r0,r1 -> 15
    vecs[5]  = '{8'h93, 2'd0, 2'd3, 1'b1, 2'd1, 4'd3,  4'd6};   // LDI r1,3
    vecs[6]  = '{8'hD0, 2'd1, 2'd0, 1'b0, 2'd0, 4'd0,  4'd0};   // JNZ r1,0 taken
    vecs[7]  = '{8'h90, 2'd0, 2'd0, 1'b1, 2'd1, 4'd0,  4'd1};   // LDI r1,0
    vecs[8]  = '{8'hD0, 2'd1, 2'd0, 1'b0, 2'd0, 4'd0,  4'd2};   // JNZ r1,0 not taken
    vecs[9]  = '{8'hFF, 2'd3, 2'd3, 1'b0, 2'd0, 4'd0,  4'd15};  // JNZ r3,15
    vecs[10] = '{8'h87, 2'd1, 2'd3, 1'b1, 2'd0, 4'd7,  4'd0};   // LDI r0,7, pc wraps
    vecs[11] = '{8'hE5, 2'd2, 2'd1, 1'b0, 2'd0, 4'd0,  4'd5};   // JNZ r2,5

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
`ifdef CTRL_STEP_EN
    step = 1'b0;
`endif

    // Reset held for 3 clocks
    repeat (3) tick();
    chk("rst_pc", pc, 0);
    chk("rst_we", write_en, 0);
    chk("rst_sel_w", sel_w, 0);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_req", instr_req, STEP_MODE ? 0 : 1);

`ifdef CTRL_STEP_EN
    instr_valid = 1'b1;
    instr_data  = 8'h95;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("step_no_req", instr_req, 0);
      chk("step_no_transfer_pc", pc, 0);
    end
    instr_valid = 1'b0;
`endif

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      pc0 = 4'(m_pc);
      model_step(vecs[i].instr, esa, esb, ewe, esw, ewd, epc);
      run_instr($sformatf("vec%0d", i), vecs[i].instr, pc0, vecs[i].sa, vecs[i].sb,
                vecs[i].we, vecs[i].sw, vecs[i].wd, vecs[i].pc);
    end

    // Fetch stall: no valid for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", instr_req, STEP_MODE ? 0 : 1);
      chk("stall_pc", pc, m_pc);
      chk("stall_we", write_en, 0);
    end

    // Reset pulsed during EXEC of LDI r2,6: the write must be dropped
    wait_req("abort");
    instr_valid = 1'b1;
    instr_data  = 8'hA6;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_we_now", write_en, 0);
    chk("abort_pc_now", pc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_we_in_rst", write_en, 0);
    end
    rst_n = 1'b1;
    m_pc  = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_we_after", write_en, 0);
      chk("abort_pc_after", pc, 0);
    end
    chk("abort_r2_kept", rf[2], m_regs[2]);

    // Random instructions against the model, with random fetch stalls
    for (int n = 0; n < 120; n++) begin
      for (int s = $urandom_range(0, 2); s > 0; s--) begin
        tick();
        chk("rand_stall_pc", pc, m_pc);
      end
      instr = 8'($urandom);
      pc0   = 4'(m_pc);
      model_step(instr, esa, esb, ewe, esw, ewd, epc);
      run_instr("rand", instr, pc0, esa, esb, ewe, esw, ewd, epc);
    end

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    for (int r = 0; r < 4; r++) chk($sformatf("final_r%0d", r), rf[r], m_regs[r]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
